// File: rtl/rv32_pkg.sv
// RV32I decode types: ALU operation encoding, control bundle, opcode constants.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package rv32_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLT    = 4'd5,
        ALU_SLTU   = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SRL    = 4'd8,
        ALU_SRA    = 4'd9,
        ALU_PASS_B = 4'd10
    } aluop_t;

    typedef struct packed {
        logic       alu_src;
        logic       alu_a_pc;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic [2:0] br_cond;
        logic [2:0] mem_size;
        aluop_t     alu_op;
    } ctrl_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Control bundle of a bubble: no side effects, ALU defaults to ADD.
    function automatic ctrl_t ctrl_nop();
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        return c;
    endfunction

endpackage

// File: rtl/rv32_decode_comb.sv
// Pure combinational RV32I decoder: control bundle, immediate, operand usage, illegal flag.
// Latency: 0 cycles (combinational).
// Backpressure: none; the enclosing stage decides when results are captured.
module rv32_decode_comb
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output ctrl_t           o_ctrl,
    output logic [XLEN-1:0] o_imm,
    output logic            o_uses_rs1,
    output logic            o_uses_rs2,
    output logic            o_illegal
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];

    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    // Opcode/funct decode; an illegal encoding collapses to the bubble bundle.
    always_comb begin
        logic [31:0] w_imm32;
        ctrl_t       w_c;
        w_c        = ctrl_nop();
        w_imm32    = '0;
        o_uses_rs1 = 1'b0;
        o_uses_rs2 = 1'b0;
        o_illegal  = 1'b0;
        unique case (w_opc)
            OPC_OP: begin
                w_c.reg_write = 1'b1;
                o_uses_rs1    = 1'b1;
                o_uses_rs2    = 1'b1;
                case (w_f3)
                    3'b000:  w_c.alu_op = (w_f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    3'b001:  w_c.alu_op = ALU_SLL;
                    3'b010:  w_c.alu_op = ALU_SLT;
                    3'b011:  w_c.alu_op = ALU_SLTU;
                    3'b100:  w_c.alu_op = ALU_XOR;
                    3'b101:  w_c.alu_op = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    3'b110:  w_c.alu_op = ALU_OR;
                    default: w_c.alu_op = ALU_AND;
                endcase
                if (!(w_f7 == F7_ZERO || (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101))))
                    o_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                w_c.alu_src   = 1'b1;
                w_c.reg_write = 1'b1;
                o_uses_rs1    = 1'b1;
                w_imm32       = w_imm_i;
                case (w_f3)
                    3'b000:  w_c.alu_op = ALU_ADD;
                    3'b001:  w_c.alu_op = ALU_SLL;
                    3'b010:  w_c.alu_op = ALU_SLT;
                    3'b011:  w_c.alu_op = ALU_SLTU;
                    3'b100:  w_c.alu_op = ALU_XOR;
                    3'b101:  w_c.alu_op = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    3'b110:  w_c.alu_op = ALU_OR;
                    default: w_c.alu_op = ALU_AND;
                endcase
                if (w_f3 == 3'b001 && w_f7 != F7_ZERO)
                    o_illegal = 1'b1;
                if (w_f3 == 3'b101 && w_f7 != F7_ZERO && w_f7 != F7_ALT)
                    o_illegal = 1'b1;
            end
            OPC_LOAD: begin
                w_c.alu_src    = 1'b1;
                w_c.mem_read   = 1'b1;
                w_c.mem_to_reg = 1'b1;
                w_c.reg_write  = 1'b1;
                w_c.mem_size   = w_f3;
                o_uses_rs1     = 1'b1;
                w_imm32        = w_imm_i;
                if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111)
                    o_illegal = 1'b1;
            end
            OPC_STORE: begin
                w_c.alu_src   = 1'b1;
                w_c.mem_write = 1'b1;
                w_c.mem_size  = w_f3;
                o_uses_rs1    = 1'b1;
                o_uses_rs2    = 1'b1;
                w_imm32       = w_imm_s;
                if (w_f3[2] || w_f3 == 3'b011)
                    o_illegal = 1'b1;
            end
            OPC_BRANCH: begin
                w_c.branch  = 1'b1;
                w_c.br_cond = w_f3;
                o_uses_rs1  = 1'b1;
                o_uses_rs2  = 1'b1;
                w_imm32     = w_imm_b;
                case (w_f3[2:1])
                    2'b00:   w_c.alu_op = ALU_SUB;
                    2'b10:   w_c.alu_op = ALU_SLT;
                    2'b11:   w_c.alu_op = ALU_SLTU;
                    default: o_illegal  = 1'b1;
                endcase
            end
            OPC_JAL: begin
                w_c.jal       = 1'b1;
                w_c.reg_write = 1'b1;
                w_imm32       = w_imm_j;
            end
            OPC_JALR: begin
                w_c.jalr      = 1'b1;
                w_c.alu_src   = 1'b1;
                w_c.reg_write = 1'b1;
                o_uses_rs1    = 1'b1;
                w_imm32       = w_imm_i;
                if (w_f3 != 3'b000)
                    o_illegal = 1'b1;
            end
            OPC_LUI: begin
                w_c.alu_src   = 1'b1;
                w_c.reg_write = 1'b1;
                w_c.alu_op    = ALU_PASS_B;
                w_imm32       = w_imm_u;
            end
            OPC_AUIPC: begin
                w_c.alu_src   = 1'b1;
                w_c.alu_a_pc  = 1'b1;
                w_c.reg_write = 1'b1;
                w_imm32       = w_imm_u;
            end
            OPC_FENCE: begin
            end
            default: o_illegal = 1'b1;
        endcase
        if (o_illegal)
            w_c = ctrl_nop();
        o_ctrl = w_c;
        o_imm  = XLEN'($signed(w_imm32));
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// Registered RV32I decode stage with load-use interlock, flush and illegal-encoding handling.
// Latency: 1 cycle from ID accept to ex_valid.
// Backpressure: EX register holds while ex_ready=0 and ex_valid=1; id_ready drops on stall or hazard.
module rv32_decode_stage
    import rv32_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit HAZARD_EN    = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic [XLEN-1:0]  id_pc,
    output logic             id_ready,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output ctrl_t            ex_ctrl,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_pc,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    ctrl_t             w_ctrl;
    logic [XLEN-1:0]   w_imm;
    logic              w_uses_rs1, w_uses_rs2, w_illegal;
    logic [4:0]        w_rs1, w_rs2, w_rd;
    logic              w_adv, w_hz;

    logic              r_valid, r_illegal;
    ctrl_t             r_ctrl;
    logic [XLEN-1:0]   r_imm, r_pc;
    logic [4:0]        r_rs1, r_rs2, r_rd;
    logic [CNT_W-1:0]  r_stall_cnt;

    rv32_decode_comb #(.XLEN(XLEN)) u_dec (
        .i_instr    (id_instr),
        .o_ctrl     (w_ctrl),
        .o_imm      (w_imm),
        .o_uses_rs1 (w_uses_rs1),
        .o_uses_rs2 (w_uses_rs2),
        .o_illegal  (w_illegal)
    );

    assign w_rs1 = id_instr[19:15];
    assign w_rs2 = id_instr[24:20];
    assign w_rd  = id_instr[11:7];

    // EX register can take a new entry when it is empty or being consumed.
    assign w_adv = ex_ready | ~r_valid;

    // A load in EX whose destination feeds the instruction in ID must wait one cycle.
    assign w_hz = HAZARD_EN & id_valid & r_valid & r_ctrl.mem_read & (r_rd != 5'd0) &
                  ((w_uses_rs1 & (w_rs1 == r_rd)) | (w_uses_rs2 & (w_rs2 == r_rd)));

    // A flushed instruction is always dropped, even while EX is stalled.
    assign id_ready = flush | (w_adv & ~w_hz);

    // EX pipeline register: flush beats hazard bubble beats normal issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_illegal   <= 1'b0;
            r_ctrl      <= ctrl_nop();
            r_imm       <= '0;
            r_pc        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_stall_cnt <= '0;
        end else if (w_adv) begin
            if (flush) begin
                r_valid   <= 1'b0;
                r_illegal <= 1'b0;
            end else if (w_hz) begin
                r_valid   <= 1'b0;
                r_illegal <= 1'b0;
                if (r_stall_cnt != {CNT_W{1'b1}})
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
                r_valid   <= id_valid & ~(w_illegal & ~ILLEGAL_TRAP);
                r_illegal <= id_valid & w_illegal & ILLEGAL_TRAP;
                r_ctrl    <= w_ctrl;
                r_imm     <= w_imm;
                r_pc      <= id_pc;
                r_rs1     <= w_rs1;
                r_rs2     <= w_rs2;
                r_rd      <= w_rd;
            end
        end
    end

    assign ex_valid   = r_valid;
    assign ex_illegal = r_illegal;
    assign ex_ctrl    = r_ctrl;
    assign ex_imm     = r_imm;
    assign ex_pc      = r_pc;
    assign ex_rs1     = r_rs1;
    assign ex_rs2     = r_rs2;
    assign ex_rd      = r_rd;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed bench for rv32_decode_stage: three instances share stimulus (default, no interlock, no trap).
// Latency: checks registered outputs one cycle after each applied vector.
// Backpressure: exercised through ex_ready and flush on all instances.
module tb_rv32_decode_stage;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = 32'h0000_0013;
    logic [31:0] id_pc = '0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b1;

    logic        a_id_ready, a_ex_valid, a_ex_illegal;
    ctrl_t       a_ex_ctrl;
    logic [31:0] a_ex_imm, a_ex_pc;
    logic [4:0]  a_ex_rs1, a_ex_rs2, a_ex_rd;
    logic [15:0] a_stall_cnt;

    logic        b_id_ready, b_ex_valid, b_ex_illegal;
    ctrl_t       b_ex_ctrl;
    logic [31:0] b_ex_imm, b_ex_pc;
    logic [4:0]  b_ex_rs1, b_ex_rs2, b_ex_rd;
    logic [15:0] b_stall_cnt;

    logic        c_id_ready, c_ex_valid, c_ex_illegal;
    ctrl_t       c_ex_ctrl;
    logic [31:0] c_ex_imm, c_ex_pc;
    logic [4:0]  c_ex_rs1, c_ex_rs2, c_ex_rd;
    logic [15:0] c_stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv32_decode_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_ready(a_id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(a_ex_valid),
        .ex_ctrl(a_ex_ctrl), .ex_imm(a_ex_imm), .ex_pc(a_ex_pc), .ex_rs1(a_ex_rs1),
        .ex_rs2(a_ex_rs2), .ex_rd(a_ex_rd), .ex_illegal(a_ex_illegal), .stall_cnt(a_stall_cnt)
    );

    rv32_decode_stage #(.HAZARD_EN(1'b0)) dut_nohz (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_ready(b_id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(b_ex_valid),
        .ex_ctrl(b_ex_ctrl), .ex_imm(b_ex_imm), .ex_pc(b_ex_pc), .ex_rs1(b_ex_rs1),
        .ex_rs2(b_ex_rs2), .ex_rd(b_ex_rd), .ex_illegal(b_ex_illegal), .stall_cnt(b_stall_cnt)
    );

    rv32_decode_stage #(.ILLEGAL_TRAP(1'b0)) dut_notrap (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_ready(c_id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(c_ex_valid),
        .ex_ctrl(c_ex_ctrl), .ex_imm(c_ex_imm), .ex_pc(c_ex_pc), .ex_rs1(c_ex_rs1),
        .ex_rs2(c_ex_rs2), .ex_rd(c_ex_rd), .ex_illegal(c_ex_illegal), .stall_cnt(c_stall_cnt)
    );

    // One clock edge; inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        n_vec++; if (a_ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_ex_valid got=%0b exp=0", a_ex_valid); end
        n_vec++; if (a_stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall_cnt got=%0d exp=0", a_stall_cnt); end
        n_vec++; if (a_ex_ctrl !== ctrl_nop()) begin n_err++; $display("FAIL reset_ex_ctrl got=%h exp=%h", a_ex_ctrl, ctrl_nop()); end
        n_vec++; if (a_ex_imm !== 32'd0 || a_ex_pc !== 32'd0 || a_ex_rd !== 5'd0) begin n_err++; $display("FAIL reset_fields imm=%h pc=%h rd=%0d exp=0", a_ex_imm, a_ex_pc, a_ex_rd); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_arith();
        ex_ready = 1'b1; id_valid = 1'b1; id_instr = 32'h0020_81B3; id_pc = 32'h100;
        tick();
        n_vec++; if (a_ex_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got=%0b exp=1", a_ex_valid); end
        n_vec++; if (a_ex_ctrl.reg_write !== 1'b1 || a_ex_ctrl.alu_op !== ALU_ADD) begin n_err++; $display("FAIL add_ctrl rw=%0b op=%0d exp rw=1 op=%0d", a_ex_ctrl.reg_write, a_ex_ctrl.alu_op, ALU_ADD); end
        n_vec++; if (a_ex_rd !== 5'd3 || a_ex_rs1 !== 5'd1 || a_ex_rs2 !== 5'd2 || a_ex_pc !== 32'h100) begin n_err++; $display("FAIL add_fields rd=%0d rs1=%0d rs2=%0d pc=%h exp 3/1/2/100", a_ex_rd, a_ex_rs1, a_ex_rs2, a_ex_pc); end
        id_instr = 32'h4020_81B3; id_pc = 32'h104;
        tick();
        n_vec++; if (a_ex_ctrl.alu_op !== ALU_SUB || a_ex_illegal !== 1'b0) begin n_err++; $display("FAIL sub_op op=%0d ill=%0b exp op=%0d ill=0", a_ex_ctrl.alu_op, a_ex_illegal, ALU_SUB); end
        id_instr = 32'hFFF0_0093; id_pc = 32'h108;
        tick();
        n_vec++; if (a_ex_imm !== 32'hFFFF_FFFF || a_ex_ctrl.alu_src !== 1'b1 || a_ex_rd !== 5'd1) begin n_err++; $display("FAIL addi_imm imm=%h src=%0b rd=%0d exp ffffffff/1/1", a_ex_imm, a_ex_ctrl.alu_src, a_ex_rd); end
        id_instr = 32'h1234_52B7; id_pc = 32'h10C;
        tick();
        n_vec++; if (a_ex_imm !== 32'h1234_5000 || a_ex_ctrl.alu_op !== ALU_PASS_B) begin n_err++; $display("FAIL lui_imm imm=%h op=%0d exp 12345000/%0d", a_ex_imm, a_ex_ctrl.alu_op, ALU_PASS_B); end
    endtask

    task automatic test_load_use();
        id_instr = 32'h0000_A283; id_pc = 32'h110;
        tick();
        n_vec++; if (a_ex_ctrl.mem_read !== 1'b1 || a_ex_ctrl.mem_size !== 3'b010 || a_ex_rd !== 5'd5) begin n_err++; $display("FAIL lw_ctrl mr=%0b sz=%0d rd=%0d exp 1/2/5", a_ex_ctrl.mem_read, a_ex_ctrl.mem_size, a_ex_rd); end
        id_instr = 32'h0022_8333; id_pc = 32'h114;
        #1;
        n_vec++; if (a_id_ready !== 1'b0) begin n_err++; $display("FAIL hz_id_ready got=%0b exp=0", a_id_ready); end
        n_vec++; if (b_id_ready !== 1'b1) begin n_err++; $display("FAIL nohz_id_ready got=%0b exp=1", b_id_ready); end
        tick();
        n_vec++; if (a_ex_valid !== 1'b0 || a_stall_cnt !== 16'd1) begin n_err++; $display("FAIL hz_bubble valid=%0b cnt=%0d exp 0/1", a_ex_valid, a_stall_cnt); end
        n_vec++; if (b_ex_valid !== 1'b1 || b_ex_rd !== 5'd6 || b_stall_cnt !== 16'd0) begin n_err++; $display("FAIL nohz_issue valid=%0b rd=%0d cnt=%0d exp 1/6/0", b_ex_valid, b_ex_rd, b_stall_cnt); end
        n_vec++; if (a_id_ready !== 1'b1) begin n_err++; $display("FAIL hz_release got=%0b exp=1", a_id_ready); end
        tick();
        n_vec++; if (a_ex_valid !== 1'b1 || a_ex_rd !== 5'd6 || a_ex_pc !== 32'h114 || a_stall_cnt !== 16'd1) begin n_err++; $display("FAIL hz_add_issue valid=%0b rd=%0d pc=%h cnt=%0d exp 1/6/114/1", a_ex_valid, a_ex_rd, a_ex_pc, a_stall_cnt); end
    endtask

    task automatic test_backpressure();
        ex_ready = 1'b0; id_instr = 32'h0050_0393; id_pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (a_id_ready !== 1'b0) begin n_err++; $display("FAIL bp_id_ready cyc=%0d got=%0b exp=0", i, a_id_ready); end
            tick();
            n_vec++; if (a_ex_valid !== 1'b1 || a_ex_rd !== 5'd6 || a_ex_pc !== 32'h114) begin n_err++; $display("FAIL bp_hold cyc=%0d valid=%0b rd=%0d pc=%h exp 1/6/114", i, a_ex_valid, a_ex_rd, a_ex_pc); end
        end
        ex_ready = 1'b1;
        #1;
        n_vec++; if (a_id_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%0b exp=1", a_id_ready); end
        tick();
        n_vec++; if (a_ex_rd !== 5'd7 || a_ex_imm !== 32'd5 || a_ex_pc !== 32'h200) begin n_err++; $display("FAIL bp_release_load rd=%0d imm=%h pc=%h exp 7/5/200", a_ex_rd, a_ex_imm, a_ex_pc); end
    endtask

    task automatic test_flush();
        ex_ready = 1'b0; flush = 1'b1; id_instr = 32'h0020_81B3; id_pc = 32'h300;
        #1;
        n_vec++; if (a_id_ready !== 1'b1) begin n_err++; $display("FAIL flush_stalled_ready got=%0b exp=1", a_id_ready); end
        tick();
        n_vec++; if (a_ex_valid !== 1'b1 || a_ex_rd !== 5'd7 || a_ex_pc !== 32'h200) begin n_err++; $display("FAIL flush_stalled_hold valid=%0b rd=%0d pc=%h exp 1/7/200", a_ex_valid, a_ex_rd, a_ex_pc); end
        ex_ready = 1'b1;
        #1;
        n_vec++; if (a_id_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got=%0b exp=1", a_id_ready); end
        tick();
        n_vec++; if (a_ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_kill valid=%0b exp=0", a_ex_valid); end
        flush = 1'b0;
    endtask

    task automatic test_branch_imm();
        id_instr = 32'hFE20_8EE3; id_pc = 32'h400;
        tick();
        n_vec++; if (a_ex_imm !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL beq_imm got=%h exp=fffffffc", a_ex_imm); end
        n_vec++; if (a_ex_ctrl.branch !== 1'b1 || a_ex_ctrl.br_cond !== 3'b000 || a_ex_ctrl.alu_op !== ALU_SUB || a_ex_ctrl.reg_write !== 1'b0) begin n_err++; $display("FAIL beq_ctrl br=%0b cond=%0d op=%0d rw=%0b exp 1/0/%0d/0", a_ex_ctrl.branch, a_ex_ctrl.br_cond, a_ex_ctrl.alu_op, ALU_SUB, a_ex_ctrl.reg_write); end
    endtask

    task automatic test_illegal();
        id_instr = 32'hFFFF_FFFF; id_pc = 32'h500;
        tick();
        n_vec++; if (a_ex_valid !== 1'b1 || a_ex_illegal !== 1'b1) begin n_err++; $display("FAIL ill_trap valid=%0b ill=%0b exp 1/1", a_ex_valid, a_ex_illegal); end
        n_vec++; if (a_ex_ctrl.reg_write !== 1'b0 || a_ex_ctrl.mem_write !== 1'b0 || a_ex_ctrl.branch !== 1'b0) begin n_err++; $display("FAIL ill_flags rw=%0b mw=%0b br=%0b exp 0/0/0", a_ex_ctrl.reg_write, a_ex_ctrl.mem_write, a_ex_ctrl.branch); end
        n_vec++; if (c_ex_valid !== 1'b0 || c_ex_illegal !== 1'b0 || c_stall_cnt !== 16'd1) begin n_err++; $display("FAIL ill_notrap valid=%0b ill=%0b cnt=%0d exp 0/0/1", c_ex_valid, c_ex_illegal, c_stall_cnt); end
        id_instr = 32'h4020_91B3; id_pc = 32'h504;
        tick();
        n_vec++; if (a_ex_illegal !== 1'b1 || a_ex_ctrl.reg_write !== 1'b0) begin n_err++; $display("FAIL ill_f7 ill=%0b rw=%0b exp 1/0", a_ex_illegal, a_ex_ctrl.reg_write); end
        id_instr = 32'h0020_81B3; id_pc = 32'h508;
        tick();
        n_vec++; if (a_ex_illegal !== 1'b0 || c_ex_valid !== 1'b1) begin n_err++; $display("FAIL ill_recover ill=%0b notrap_valid=%0b exp 0/1", a_ex_illegal, c_ex_valid); end
    endtask

    task automatic test_async_reset();
        n_vec++; if (a_ex_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre valid=%0b exp=1", a_ex_valid); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (a_ex_valid !== 1'b0 || a_stall_cnt !== 16'd0) begin n_err++; $display("FAIL arst_now valid=%0b cnt=%0d exp 0/0", a_ex_valid, a_stall_cnt); end
        n_vec++; if (a_ex_ctrl.alu_op !== ALU_ADD || a_ex_rd !== 5'd0 || a_ex_illegal !== 1'b0) begin n_err++; $display("FAIL arst_fields op=%0d rd=%0d ill=%0b exp %0d/0/0", a_ex_ctrl.alu_op, a_ex_rd, a_ex_illegal, ALU_ADD); end
        @(negedge clk);
        rst = 1'b0;
        id_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_load_use();
        test_backpressure();
        test_flush();
        test_branch_imm();
        test_illegal();
        test_async_reset();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rv32_decode_stage.md
Name: rv32_decode_stage

Overview:
- Registered RV32I instruction-decode stage. It sits between the IF/ID latch and the execute stage.
- Decodes the full RV32I base set (except SYSTEM) into a control bundle, ALU operation and sign-extended immediate.
- Detects load-use hazards and inserts bubbles. Honours downstream backpressure and pipeline flush.
- Flags illegal encodings and counts hazard stalls.

Parameters:
- XLEN, 32, datapath/PC/immediate width; must be >= 32; immediates sign-extended to XLEN.
- HAZARD_EN, 1, 1 = load-use interlock active; 0 = no hazard stalls (external scheme handles them).
- ILLEGAL_TRAP, 1, 1 = illegal instr propagates to EX with ex_illegal=1; 0 = illegal instr becomes a bubble.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- id_valid  in  1  fetched instruction valid.
- id_instr  in  32  instruction word.
- id_pc  in  XLEN  PC of id_instr.
- id_ready  out  1  decode accepts id_instr this cycle.
- flush  in  1  kill instruction in ID and do not issue to EX.
- ex_ready  in  1  EX consumes the ex_* register this cycle.
- ex_valid  out  1  ex_* register holds a live instruction.
- ex_ctrl  out  rv32_pkg::ctrl_t  decoded control bundle.
- ex_imm  out  XLEN  sign-extended immediate.
- ex_pc  out  XLEN  PC of the EX instruction.
- ex_rs1  out  5  source register 1 index.
- ex_rs2  out  5  source register 2 index.
- ex_rd  out  5  destination register index.
- ex_illegal  out  1  EX instruction is an illegal encoding.
- stall_cnt  out  CNT_W  count of load-use bubbles inserted.

Behaviour:
- Reset (async, immediate on rst rising):
  - ex_valid=0, ex_illegal=0, stall_cnt=0.
  - ex_imm, ex_pc, ex_rs1, ex_rs2, ex_rd = 0.
  - ex_ctrl all flags 0, alu_op=ALU_ADD.
- adv = ex_ready | ~ex_valid. The EX register loads only when adv=1; otherwise every ex_* output holds.
- Load-use hazard:
  - hz = HAZARD_EN & id_valid & ex_valid & ex_ctrl.mem_read & (ex_rd!=0) & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
  - uses_rs1: OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - uses_rs2: OP, STORE, BRANCH.
- id_ready = flush | (adv & ~hz). Combinational; no dependency on id_valid.
- Priority at an adv edge:
  - flush: ex_valid<=0.
  - else hz: ex_valid<=0 (bubble), stall_cnt+=1 (saturates at all-ones).
  - else: ex_valid<=id_valid and all ex_* fields load from decode.
- Flush while adv=0: the EX register holds and the ID instruction is still dropped (id_ready=1).
- Decode; default controls are all 0 with alu_op=ALU_ADD:
  - OP (0110011): reg_write. funct3 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND. funct7=0100000 is legal only with f3=000 (SUB) and f3=101 (SRA). Any other funct7 is illegal.
  - OP-IMM (0010011): alu_src, reg_write. SLLI requires funct7=0. SRLI/SRAI require funct7 = 0 or 0100000.
  - LOAD (0000011): alu_src, mem_read, mem_to_reg, reg_write. mem_size=funct3. Legal f3 = 000, 001, 010, 100, 101.
  - STORE (0100011): alu_src, mem_write. Legal f3 = 000, 001, 010.
  - BRANCH (1100011): branch, br_cond=funct3. alu_op: SUB for f3 000/001, SLT for 100/101, SLTU for 110/111. f3 010/011 are illegal.
  - JAL (1101111): jal, reg_write.
  - JALR (1100111): jalr, alu_src, reg_write; f3 must be 000.
  - LUI (0110111): alu_src, reg_write, alu_op=ALU_PASS_B.
  - AUIPC (0010111): alu_src, alu_a_pc, reg_write, ADD.
  - FENCE (0001111): legal no-op.
  - Every other opcode, and any instruction with id_instr[1:0]!=11, is illegal.
- Immediates by format: I, S, B (bit0=0), U (low 12 bits=0), J (bit0=0); sign-extended from instr[31].
- Illegal with ILLEGAL_TRAP=1: ex_valid=1, ex_illegal=1, all write/mem/branch/jump flags forced 0.
- Illegal with ILLEGAL_TRAP=0: issued as a bubble (ex_valid=0); stall_cnt unchanged.
- Latency: 1 cycle from ID accept to ex_valid.
- Throughput: 1 instruction per cycle with no hazard and no backpressure.

Decomposition:
- rv32_pkg gets:
  - aluop_t extended with XOR, SLTU, SLL, SRL, SRA, PASS_B.
  - ctrl_t packed struct: alu_src, alu_a_pc, mem_read, mem_write, mem_to_reg, reg_write, branch, jal, jalr, br_cond[2:0], mem_size[2:0], alu_op.
  - Opcode localparams OPC_*.
- One sub-module: rv32_decode_comb, the pure combinational decoder. Outputs: ctrl_t, imm, uses_rs1/rs2, illegal.

Test Plan:
- Async reset: assert rst mid-stream with ex_valid=1 -> same-cycle ex_valid=0, stall_cnt=0, ex_ctrl.alu_op=ALU_ADD.
- Arithmetic decode:
  - 0x002081B3 (ADD x3,x1,x2), ex_ready=1 -> next cycle ex_valid=1, reg_write=1, alu_op=ALU_ADD, ex_rd=3.
  - 0x402081B3 -> alu_op=ALU_SUB.
- Load-use: 0x0000A283 (LW x5,0(x1)) then 0x00228333 (ADD x6,x5,x2):
  - hazard cycle -> id_ready=0, one bubble, stall_cnt=1.
  - ADD issues on the following cycle.
  - With HAZARD_EN=0 -> no bubble, stall_cnt stays 0.
- Backpressure: hold ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable and id_ready=0. Release -> next instruction loads on the first adv edge.
- Flush and immediate:
  - flush=1 with id_valid=1 -> id_ready=1, next cycle ex_valid=0.
  - 0xFE208EE3 (BEQ x1,x2,-4) -> ex_imm=0xFFFFFFFC, branch=1, br_cond=000.
- Illegal: 0xFFFFFFFF -> ex_illegal=1, reg_write=0, mem_write=0. With ILLEGAL_TRAP=0 -> ex_valid=0, stall_cnt unchanged.
